// File: rtl/vegeta_weight_loader.sv
// Weight loader for the vegeta PE array: compresses dense weight rows to N:M form
// and streams ROWS of them into the top of a PE column with double-buffer select.
module vegeta_weight_loader #(
  parameter int MUL_DATAWIDTH  = 8,
  parameter int META_DATA_SIZE = 2,
  parameter int M              = 4,
  parameter int BETA           = 4,
  parameter int ALPHA          = 4,
  parameter int ROWS           = 8
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic [1:0]                                             gemm_mode_in,
  input  logic                                                   w_valid,
  output logic                                                   w_ready,
  input  logic [ALPHA*M*MUL_DATAWIDTH-1:0]                       w_data,
  output logic [ALPHA*BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0]   weight_out,
  output logic                                                   weight_transferring_out,
  output logic                                                   i_wb,
  output logic [1:0]                                             gemm_mode,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   nm_err
);

  localparam int DW    = MUL_DATAWIDTH;
  localparam int SW    = MUL_DATAWIDTH + META_DATA_SIZE;
  localparam int OW    = ALPHA * BETA * SW;
  localparam int CW    = $clog2(ROWS + 1);
  localparam int N_2_4 = (BETA < 2) ? BETA : 2;
  localparam int N_1_4 = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   row_cnt;
  logic            beat;
  logic            last_beat;
  logic            sparse;
  int              n_keep;
  int              cnt;
  logic [DW-1:0]   elem;
  logic [OW-1:0]   comp_row;
  logic            comp_err;

  assign w_ready   = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign beat      = w_valid && w_ready;
  assign last_beat = beat && (row_cnt == CW'(ROWS - 1));
  assign sparse    = (gemm_mode == 2'b01) || (gemm_mode == 2'b10);

  // Mode 11 is reserved and falls back to the dense packing.
  always_comb begin
    n_keep = BETA;
    if (gemm_mode == 2'b01)
      n_keep = N_2_4;
    else if (gemm_mode == 2'b10)
      n_keep = N_1_4;
  end

  always_comb begin
    comp_row = '0;
    comp_err = 1'b0;
    cnt      = 0;
    elem     = '0;
    for (int g = 0; g < ALPHA; g++) begin
      cnt = 0;
      for (int k = 0; k < M; k++) begin
        elem = w_data[(g*M + k)*DW +: DW];
        if (!sparse) begin
          if (k < BETA)
            comp_row[(g*BETA + k)*SW +: SW] = {META_DATA_SIZE'(k), elem};
        end else if (elem != '0) begin
          // Nonzeros beyond N are dropped; the first N in scan order win.
          if (cnt < n_keep)
            comp_row[(g*BETA + cnt)*SW +: SW] = {META_DATA_SIZE'(k), elem};
          else
            comp_err = 1'b1;
          cnt = cnt + 1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (last_beat) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= S_IDLE;
      weight_out              <= '0;
      weight_transferring_out <= 1'b0;
      i_wb                    <= 1'b0;
      gemm_mode               <= 2'b00;
      nm_err                  <= 1'b0;
      row_cnt                 <= '0;
    end else begin
      state                   <= state_next;
      weight_transferring_out <= beat;
      if (beat) begin
        weight_out <= comp_row;
        row_cnt    <= row_cnt + CW'(1);
        if (comp_err)
          nm_err <= 1'b1;
      end
      if (state == S_IDLE && start) begin
        gemm_mode <= gemm_mode_in;
        nm_err    <= 1'b0;
        row_cnt   <= '0;
      end
      // Flip the shadow buffer only once the whole load has been delivered.
      if (state == S_DONE)
        i_wb <= ~i_wb;
    end
  end

endmodule
